// File: rtl/decoder_scan.sv
// decoder_scan: registered N-to-2^N decoder with active-low one-hot outputs
// and an auto-scan mode that steps the index at a programmable rate.
// Optional feature macro: DECODER_SCAN_PINGPONG_EN (bounce at the endpoints
// instead of wrapping; dir is then latched only on load, rst or mode=0).
module decoder_scan #(
   parameter int N   = 3,
   parameter int DIV = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en_n,
   input  logic              mode,
   input  logic              dir,
   input  logic              load,
   input  logic [N-1:0]      sel,
   output logic [2**N-1:0]   y,
   output logic [N-1:0]      idx,
   output logic              wrap
);

   localparam int W  = 2**N;
   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
   localparam logic [N-1:0]  IDX_MAX = {N{1'b1}};

   logic [CW-1:0] cnt, cnt_nx;
   logic          dir_r, dir_nx;
   logic [N-1:0]  idx_nx;
   logic          wrap_nx;
   logic [W-1:0]  y_nx;

   // Active-low one-hot decode of an index.
   function automatic logic [W-1:0] decode(input logic [N-1:0] i);
      logic [W-1:0] oh;
      oh    = '0;
      oh[i] = 1'b1;
      return ~oh;
   endfunction

   // Next-state selection in priority order: load, freeze, direct, scan.
   always_comb begin
      idx_nx  = idx;
      cnt_nx  = cnt;
      dir_nx  = dir_r;
      wrap_nx = 1'b0;
      if (load) begin
         idx_nx = sel;
         cnt_nx = '0;
         dir_nx = dir;
      end else if (en_n) begin
         // frozen: hold index, prescaler and direction
      end else if (!mode) begin
         idx_nx = sel;
         cnt_nx = '0;
         dir_nx = dir;
      end else begin
`ifndef DECODER_SCAN_PINGPONG_EN
         dir_nx = dir;
`endif
         if (cnt == CNT_MAX) begin
            cnt_nx = '0;
`ifdef DECODER_SCAN_PINGPONG_EN
            // At an endpoint reverse and step back inward.
            if (!dir_r) begin
               if (idx == IDX_MAX) begin
                  idx_nx  = idx - 1'b1;
                  dir_nx  = 1'b1;
                  wrap_nx = 1'b1;
               end else begin
                  idx_nx = idx + 1'b1;
               end
            end else begin
               if (idx == '0) begin
                  idx_nx  = idx + 1'b1;
                  dir_nx  = 1'b0;
                  wrap_nx = 1'b1;
               end else begin
                  idx_nx = idx - 1'b1;
               end
            end
`else
            // Modular step; the index arithmetic wraps naturally.
            if (!dir_r) begin
               idx_nx  = idx + 1'b1;
               wrap_nx = (idx == IDX_MAX);
            end else begin
               idx_nx  = idx - 1'b1;
               wrap_nx = (idx == '0);
            end
`endif
         end else begin
            cnt_nx = cnt + 1'b1;
         end
      end
      // y tracks the next index so y and idx always change together.
      y_nx = en_n ? {W{1'b1}} : decode(idx_nx);
   end

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx   <= '0;
         cnt   <= '0;
         dir_r <= 1'b0;
         y     <= {W{1'b1}};
         wrap  <= 1'b0;
      end else begin
         idx   <= idx_nx;
         cnt   <= cnt_nx;
         dir_r <= dir_nx;
         y     <= y_nx;
         wrap  <= wrap_nx;
      end
   end

endmodule

// File: tb/tb_decoder_scan.sv
// tb_decoder_scan: directed checks of decoder_scan (N=3, DIV=4), plus a
// bounce sequence on a DIV=1 instance when DECODER_SCAN_PINGPONG_EN is set.
module tb_decoder_scan;

   logic       clk;
   logic       rst;
   logic       en_n;
   logic       mode;
   logic       dir;
   logic       load;
   logic [2:0] sel;
   logic [7:0] y;
   logic [2:0] idx;
   logic       wrap;

   int total;
   int bad;

   decoder_scan #(.N(3), .DIV(4)) dut (
      .clk  (clk),
      .rst  (rst),
      .en_n (en_n),
      .mode (mode),
      .dir  (dir),
      .load (load),
      .sel  (sel),
      .y    (y),
      .idx  (idx),
      .wrap (wrap)
   );

`ifdef DECODER_SCAN_PINGPONG_EN
   logic [7:0] y2;
   logic [2:0] idx2;
   logic       wrap2;

   decoder_scan #(.N(3), .DIV(1)) dut2 (
      .clk  (clk),
      .rst  (rst),
      .en_n (en_n),
      .mode (mode),
      .dir  (dir),
      .load (load),
      .sel  (sel),
      .y    (y2),
      .idx  (idx2),
      .wrap (wrap2)
   );
`endif

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Compare one observed value against its expected value.
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Advance one rising edge and settle just past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [7:0] dec_tab [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      en_n  = 1'b0;
      mode  = 1'b0;
      dir   = 1'b0;
      load  = 1'b0;
      sel   = 3'd0;

      // Reset held two cycles
      tick();
      chk("rst_idx", 32'(idx), 32'd0);
      chk("rst_y", 32'(y), 32'hFF);
      chk("rst_wrap", 32'(wrap), 32'd0);
      tick();
      rst = 1'b0;
      tick();
      chk("post_rst_y", 32'(y), 32'hFE);
      chk("post_rst_idx", 32'(idx), 32'd0);

      // Direct decode
      sel = 3'd5;
      tick();
      chk("dir5_idx", 32'(idx), 32'd5);
      chk("dir5_y", 32'(y), 32'hDF);
      for (int i = 0; i < 8; i++) begin
         sel = 3'(i);
         tick();
         chk($sformatf("sweep_y%0d", i), 32'(y), 32'(dec_tab[i]));
         chk($sformatf("sweep_idx%0d", i), 32'(idx), 32'(i));
      end

`ifndef DECODER_SCAN_PINGPONG_EN
      // Auto-scan up from 6 with wrap
      load = 1'b1; sel = 3'd6; mode = 1'b1; dir = 1'b0;
      tick();
      load = 1'b0;
      chk("up_load_idx", 32'(idx), 32'd6);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("up_hold6", 32'(idx), 32'd6);
      end
      tick();
      chk("up_step7", 32'(idx), 32'd7);
      chk("up_step7_wrap", 32'(wrap), 32'd0);
      chk("up_step7_y", 32'(y), 32'h7F);
      for (int k = 0; k < 3; k++) tick();
      chk("up_hold7", 32'(idx), 32'd7);
      tick();
      chk("up_wrap_idx", 32'(idx), 32'd0);
      chk("up_wrap", 32'(wrap), 32'd1);
      chk("up_wrap_y", 32'(y), 32'hFE);
      tick();
      chk("up_wrap_pulse", 32'(wrap), 32'd0);

      // Down scan from 1, wrap 0 -> 7, then freeze mid-interval
      load = 1'b1; sel = 3'd1; dir = 1'b1;
      tick();
      load = 1'b0;
      for (int k = 0; k < 4; k++) tick();
      chk("dn_step0", 32'(idx), 32'd0);
      chk("dn_step0_wrap", 32'(wrap), 32'd0);
      for (int k = 0; k < 4; k++) tick();
      chk("dn_wrap_idx", 32'(idx), 32'd7);
      chk("dn_wrap", 32'(wrap), 32'd1);
      chk("dn_wrap_y", 32'(y), 32'h7F);
      tick();
      tick();
      en_n = 1'b1;
      tick();
      chk("frz_y", 32'(y), 32'hFF);
      chk("frz_wrap", 32'(wrap), 32'd0);
      for (int k = 0; k < 9; k++) tick();
      chk("frz_idx", 32'(idx), 32'd7);
      chk("frz_y_end", 32'(y), 32'hFF);
      en_n = 1'b0;
      tick();
      chk("rel_idx", 32'(idx), 32'd7);
      chk("rel_y", 32'(y), 32'h7F);
      tick();
      chk("rel_step", 32'(idx), 32'd6);
      chk("rel_step_y", 32'(y), 32'hBF);

      // Load on the cycle the prescaler would step
      for (int k = 0; k < 3; k++) tick();
      load = 1'b1; sel = 3'd3; dir = 1'b0;
      tick();
      load = 1'b0;
      chk("ld_idx", 32'(idx), 32'd3);
      for (int k = 0; k < 3; k++) tick();
      chk("ld_hold", 32'(idx), 32'd3);
      tick();
      chk("ld_step", 32'(idx), 32'd4);
      chk("ld_step_y", 32'(y), 32'hEF);
`else
      // Bounce sequence on the DIV=1 instance starting at 5 going up
      begin
         logic [2:0] seq  [12] = '{3'd6, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd1, 3'd2, 3'd3};
         logic       wseq [12] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
         load = 1'b1; sel = 3'd5; mode = 1'b1; dir = 1'b0;
         tick();
         load = 1'b0;
         dir  = 1'b1;
         chk("pp_load", 32'(idx2), 32'd5);
         for (int k = 0; k < 12; k++) begin
            tick();
            chk($sformatf("pp_idx%0d", k), 32'(idx2), 32'(seq[k]));
            chk($sformatf("pp_wrap%0d", k), 32'(wrap2), 32'(wseq[k]));
         end
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
